// File: rtl/imem_prog.sv
// ---------------------------------------------------------------------------
// imem_prog -- loadable instruction memory for the pipelined core
//
// This replaces the old fixed ROM that had a combinational read. Fetches come
// from the PC register and land in q one cycle later, where the IF/ID register
// picks them up. A sequential programming port loads the array word by word at
// run time through an auto-incrementing write pointer.
//
// Parameters:
//   N      instruction word width
//   AW     word-address width (addr = PC[AW+1:2])
//   DEPTH  words implemented, DEPTH <= 2**AW
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   addr           fetch word address
//   rd_en          fetch request
//   stall          hold q / q_valid / q_perr
//   q              registered instruction
//   q_valid        q answers the request issued on the previous cycle
//   q_perr         parity mismatch on the word in q
//   prog_start     enter load mode (restarts pointer and count)
//   prog_we        write prog_data at the write pointer
//   prog_data      word to load
//   prog_end       leave load mode
//   prog_par_flip  store inverted parity for this write (fault injection)
//   prog_busy      load mode active
//   prog_done      one-cycle pulse when a load completes
//   prog_count     words written by the current or last load
//
// Build option:
//   IMEM_PARITY_EN  when defined, each word carries an even-parity bit that is
//                   checked on every fetch. When undefined, q_perr is tied low
//                   and prog_par_flip is ignored.
// ---------------------------------------------------------------------------
module imem_prog #(
   parameter int N     = 32,
   parameter int AW    = 6,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] addr,
   input  logic          rd_en,
   input  logic          stall,
   output logic [N-1:0]  q,
   output logic          q_valid,
   output logic          q_perr,
   input  logic          prog_start,
   input  logic          prog_we,
   input  logic [N-1:0]  prog_data,
   input  logic          prog_end,
   input  logic          prog_par_flip,
   output logic          prog_busy,
   output logic          prog_done,
   output logic [AW:0]   prog_count
);

   // Index width of the implemented array; narrower than AW when DEPTH is
   // smaller than the address space.
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW1 = AW + 1;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Even parity: the stored bit makes the total number of ones even.
   function automatic logic even_par(input logic [N-1:0] d);
      return ^d;
   endfunction

   // Storage. Contents are not reset; they start at zero and keep whatever was
   // loaded across a reset.
   logic [N-1:0] mem [DEPTH] = '{default: '0};

   logic [IW-1:0] ptr;
   logic [IW-1:0] raddr_p0;
   logic          in_range_p0;
   logic [N-1:0]  rdata_p0;
   logic          perr_p0;
   logic          rd_fire_p0;
   logic          wr_fire;

   logic [N-1:0]  q_p1;
   logic          vld_p1;
   logic          perr_p1;

   assign raddr_p0 = addr[IW-1:0];

   // Addresses past the implemented words read as zero instead of wrapping.
   generate
      if (DEPTH < (2 ** AW)) begin : g_partial
         assign in_range_p0 = ({1'b0, addr} < AW1'(DEPTH));
      end else begin : g_full
         assign in_range_p0 = 1'b1;
      end
   endgenerate

   // The write port is only live in LOAD and the read port only in RUN, so the
   // array never sees a read and a write in the same cycle.
   assign wr_fire    = (state == LOAD) && prog_we;
   assign rd_fire_p0 = (state == RUN) && !prog_start && !stall && rd_en;

   assign rdata_p0 = in_range_p0 ? mem[raddr_p0] : '0;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[ptr] <= prog_data;
      end
   end

`ifdef IMEM_PARITY_EN
   logic par_mem [DEPTH] = '{default: 1'b0};

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         par_mem[ptr] <= even_par(prog_data) ^ prog_par_flip;
      end
   end

   assign perr_p0 = in_range_p0 && (even_par(mem[raddr_p0]) != par_mem[raddr_p0]);
`else
   logic unused_par_flip;
   assign unused_par_flip = prog_par_flip;
   assign perr_p0         = 1'b0;
`endif

   // ---- state register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (prog_start) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            // A write into the last word ends the load even without prog_end.
            if (prog_end || (prog_we && (ptr == LAST))) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // ---- state-decoded outputs ----
   always_comb begin
      prog_busy = 1'b0;
      prog_done = 1'b0;
      case (state)
         LOAD:    prog_busy = 1'b1;
         DONE:    prog_done = 1'b1;
         default: ;
      endcase
   end

   // ---- p0 -> p1: fetch register and load pointer ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_p1       <= '0;
         vld_p1     <= 1'b0;
         perr_p1    <= 1'b0;
         ptr        <= '0;
         prog_count <= '0;
      end else begin
         case (state)
            RUN: begin
               if (prog_start) begin
                  vld_p1     <= 1'b0;
                  ptr        <= '0;
                  prog_count <= '0;
               end else if (!stall) begin
                  vld_p1 <= rd_en;
                  if (rd_fire_p0) begin
                     q_p1    <= rdata_p0;
                     perr_p1 <= perr_p0;
                  end
               end
            end
            LOAD: begin
               vld_p1 <= 1'b0;
               if (prog_we) begin
                  ptr        <= ptr + IW'(1);
                  prog_count <= prog_count + AW1'(1);
               end
            end
            default: begin
               vld_p1 <= 1'b0;
            end
         endcase
      end
   end

   assign q       = q_p1;
   assign q_valid = vld_p1;
   assign q_perr  = perr_p1;

endmodule

// File: doc/imem_prog.md
Name: imem_prog

Overview:
- Parametrised, loadable instruction memory for the pipelined core. It replaces the fixed 64x32 ROM that had a combinational read.
- The read port is synchronous with 1-cycle latency and supports a fetch stall input.
- A sequential programming port loads a program word-by-word at run time through an auto-incrementing write pointer.
- The block sits between the fetch-stage PC register and the IF/ID pipeline register.

Parameters:
- N, 32, instruction word width in bits.
- AW, 6, word-address width.
- DEPTH, 64, number of words implemented; must satisfy DEPTH <= 2**AW.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  AW  word address from PC (PC[AW+1:2]).
- rd_en  in  1  fetch request.
- stall  in  1  hold current q/q_valid (pipeline stall).
- q  out  N  fetched instruction, registered.
- q_valid  out  1  q holds data for the request issued last cycle.
- q_perr  out  1  parity error on current q (see Optional Feature).
- prog_start  in  1  enter load mode.
- prog_we  in  1  write prog_data at the write pointer.
- prog_data  in  N  word to load.
- prog_end  in  1  terminate load mode.
- prog_par_flip  in  1  fault injection: store inverted parity for this write.
- prog_busy  out  1  load mode active.
- prog_done  out  1  one-cycle pulse when a load completes.
- prog_count  out  AW+1  number of words written in the current or last load.

Behaviour:
- Reset (asynchronous, takes effect immediately) sets:
  - FSM to RUN;
  - q=0, q_valid=0, q_perr=0;
  - prog_busy=0, prog_done=0;
  - write pointer=0, prog_count=0.
- Memory array is not reset. Its contents are all-zero at time 0 via initialisation.
- FSM states: RUN, LOAD, DONE.
- RUN:
  - If stall=1: q, q_valid and q_perr hold.
  - Else if rd_en=1: next edge q <= MEM[addr], q_valid <= 1.
  - Else: q_valid <= 0 and q holds.
  - Read latency is exactly 1 cycle.
  - addr >= DEPTH returns q=0 with q_valid=1 (no wrap).
  - prog_start=1 moves the FSM to LOAD; pointer <= 0, prog_count <= 0, q_valid <= 0. prog_start takes priority over rd_en in the same cycle.
- LOAD:
  - prog_busy=1. q_valid is forced to 0; rd_en and stall are ignored; q holds.
  - prog_we=1: MEM[ptr] <= prog_data, ptr++, prog_count++.
  - Move to DONE when prog_end=1, or when a write occurs with ptr == DEPTH-1 (memory full).
  - prog_we and prog_end in the same cycle: the word is written, then the FSM goes to DONE.
  - prog_we with ptr >= DEPTH cannot occur, because the full condition exits first.
  - prog_start in LOAD is ignored and does not restart the pointer.
- DONE:
  - prog_done=1 and prog_busy=0 for exactly one cycle, then RUN.
  - prog_count holds until the next prog_start or reset.
- Reset mid-load: FSM goes to RUN and the pointer to 0. Words already written stay in memory. No prog_done pulse is produced.
- A read in the first RUN cycle after DONE returns the newly loaded data. No bypass from an in-flight write is required.
- Memory infers as synchronous-read block RAM: one write port, one read port, never active in the same cycle.

Optional Feature:
- Macro name: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from prog_data on write; prog_par_flip=1 inverts the stored bit.
  - On a read, q_perr <= (^MEM_data) != stored_parity, registered alongside q and held under stall.
  - addr >= DEPTH gives q_perr=0.
- Undefined: no parity storage; q_perr tied 0; prog_par_flip unused.

Test Plan:
- Reset then read: assert reset mid-cycle; q=0 and q_valid=0 immediately. Release reset, rd_en=1, addr=5 → next cycle q=0, q_valid=1.
- Load then fetch: prog_start, then write 32'hf8000000, 32'hf8008001, 32'hb400004e with prog_end on the third → prog_done pulse, prog_count=3. rd_en with addr=2 → q=32'hb400004e one cycle later.
- Stall hold: read addr=1 (q=32'hf8008001), then stall=1 for 3 cycles while addr changes to 0 → q and q_valid unchanged; on stall release, q=32'hf8000000 on the next edge.
- Full load: DEPTH=64, 64 consecutive prog_we without prog_end → DONE after the 64th write, prog_count=64. Reading addr=63 returns the 64th word.
- Reset mid-load: load 10 words, assert reset → prog_busy=0, no prog_done, prog_count=0. addr=9 reads the 10th word; addr=10 reads 0.
- With IMEM_PARITY_EN: load word 32'h00000001 with prog_par_flip=1 at addr 0 and a normal word at addr 1 → reading addr 0 gives q_perr=1, addr 1 gives q_perr=0. Without the macro, q_perr=0 always.
